mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares one single-ported, variable-latency memory between the core's instruction-fetch port and its load/store port. It sits between `core` and the unified memory, serialises the two requesters, and freezes the pipeline with a stall signal until every request of the current pipeline cycle has been acknowledged. It also runs a per-access watchdog that aborts and flags hung accesses.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum wait cycles for `i_con_mem_ack` per access, 1..255.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_con_ireq`  in  1  instruction fetch request; held stable while `o_con_stall`=1.
- `i_addr_instr`  in  32  fetch address (PC).
- `o_data_instr`  out  32  fetched word, registered.
- `i_con_dread`  in  1  load request.
- `i_con_dwrite`  in  1  store request; `dread` and `dwrite` are never both 1.
- `i_addr_data`  in  32  load/store address.
- `i_data_wdata`  in  32  store data.
- `o_data_rdata`  out  32  load word, registered.
- `o_con_stall`  out  1  pipeline freeze, combinational.
- `o_con_mem_req`  out  1  memory request, registered.
- `o_con_mem_we`  out  1  memory write enable, registered.
- `o_addr_mem`  out  32  memory address, registered.
- `o_data_memw`  out  32  memory write data, registered.
- `i_con_mem_ack`  in  1  memory acknowledge, one-cycle pulse.
- `i_data_memr`  in  32  memory read data, valid with ack.
- `o_con_err`  out  1  sticky timeout flag.

## Operation
- FSM states: `IDLE`, `D_BUSY`, `I_BUSY`.
- Pending conditions:
  - data pending = (`dread`|`dwrite`) & ~`d_done`.
  - instruction pending = `ireq` & ~`i_done`.
- `IDLE`:
  - Data pending -> `D_BUSY`. Data wins over fetch because it belongs to the older instruction.
  - Otherwise, instruction pending -> `I_BUSY`.
  - On entry, register req=1, address, `we`=`dwrite` (0 for fetch), write data.
- Busy states:
  - req, address, we and write data hold stable until ack.
  - On ack, set the matching done flag.
  - On a read ack, latch `i_data_memr` into `o_data_rdata` or `o_data_instr`.
  - After ack: if the other side is still pending, go directly to its busy state with req held 1 and the new address. Otherwise go to `IDLE` with req=0.
- `o_con_stall` = instruction pending | data pending.
- Done flags clear on any edge where `o_con_stall`=0, which is the edge on which the core advances.
- Watchdog:
  - Counter resets on entry to each busy state.
  - If it reaches `TIMEOUT` without ack: set `o_con_err`, set that side's done flag, load 0 into its read-data register, drop req, go to `IDLE`.
  - An ack arriving in `IDLE` is ignored.
- Stores return no data; `o_data_rdata` is unchanged by a store ack.

## Timing
- Reset values:
  - state `IDLE`.
  - `o_con_mem_req`=0, `o_con_mem_we`=0.
  - `o_addr_mem`=0, `o_data_memw`=0.
  - `o_data_instr`=0, `o_data_rdata`=0.
  - `o_con_err`=0, done flags 0, watchdog 0.
- Reset mid-access abandons the access; req=0 on the cycle after the reset edge.
- Request in cycle N with memory ack in cycle N+k: req high N+1..N+k, data registered at the N+k edge, stall low in cycle N+k+1.
- Single access: stall for k+1 cycles.
- Load + fetch in the same cycle with acks after k1 and k2 cycles: stall for k1+k2+1 cycles. The fetch request is issued in the cycle after the data ack, with no `IDLE` bubble.
- Requests arriving while stall is low start arbitration in that same cycle.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`, `D_BUSY`, `I_BUSY`);
  - `ARB_DW`=32;
  - `ARB_TIMEOUT_DEFAULT`=255.
- One natural sub-module: `arb_watchdog`, an 8-bit counter with clear/enable inputs and an `expired` output.

## Test plan
- Fetch only, `i_addr_instr`=0x100, ack after 3 cycles with 0x2402_0005 -> stall 4 cycles, `o_data_instr`=0x24020005, req low afterwards.
- Load 0x200 + fetch 0x104 in the same cycle, both acks at latency 2 -> memory sees 0x200 then 0x104 back-to-back, stall 5 cycles, `o_data_rdata` and `o_data_instr` both correct.
- Store 0xCAFEBABE to 0x300 -> `o_con_mem_we`=1 with stable address and data until ack, `o_data_rdata` unchanged.
- `TIMEOUT`=4, no ack -> req drops after 4 wait cycles, `o_con_err`=1 and stays 1, stall released, read data=0.
- Reset asserted in `D_BUSY` -> next cycle req=0, state `IDLE`, all outputs at reset values, a late ack is ignored.
- Back-to-back fetches with zero-wait ack (ack on the first req cycle) -> stall exactly 2 cycles per fetch, no lost or duplicated requests.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t         : arbiter FSM state (IDLE, D_BUSY, I_BUSY)
//   ARB_DW              : data and address width of every port
//   ARB_TIMEOUT_DEFAULT : default watchdog limit in wait cycles
//   ARB_WD_W            : width of the watchdog counter
package mem_arb_pkg;

  localparam int unsigned ARB_DW              = 32;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
  localparam int unsigned ARB_WD_W            = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Per-access watchdog counter for the memory arbiter.
// Counts wait cycles of the access in flight and flags the cycle on which the
// limit is reached.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_clr     : clear the counter (takes priority over i_en)
//   i_en      : count this cycle (access in flight, no ack)
//   i_limit   : number of wait cycles allowed, 1..255
//   o_expired : this is the i_limit-th wait cycle without ack
module arb_watchdog
  import mem_arb_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [ARB_WD_W-1:0] i_limit,
  output logic                o_expired
);

  logic [ARB_WD_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds completed wait cycles, so the current cycle is number r_count+1.
  assign o_expired = i_en && (r_count == (i_limit - 1'b1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port and the load/store port of the core. Requests of one
// pipeline cycle are serialised (data first), the pipeline is frozen with
// o_con_stall until all of them are acknowledged, and a watchdog aborts
// accesses that never get an ack.
//   i_clk, i_rst                  : clock and synchronous active-high reset
//   i_con_ireq, i_addr_instr      : fetch request and PC
//   o_data_instr                  : fetched word (registered)
//   i_con_dread, i_con_dwrite     : load / store request (never both)
//   i_addr_data, i_data_wdata     : load/store address and store data
//   o_data_rdata                  : loaded word (registered)
//   o_con_stall                   : pipeline freeze (combinational)
//   o_con_mem_req/_we, o_addr_mem,
//   o_data_memw                   : memory request bundle (registered)
//   i_con_mem_ack, i_data_memr    : memory ack pulse and read data
//   o_con_err                     : sticky timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_con_ireq,
  input  logic [ARB_DW-1:0] i_addr_instr,
  output logic [ARB_DW-1:0] o_data_instr,
  input  logic              i_con_dread,
  input  logic              i_con_dwrite,
  input  logic [ARB_DW-1:0] i_addr_data,
  input  logic [ARB_DW-1:0] i_data_wdata,
  output logic [ARB_DW-1:0] o_data_rdata,
  output logic              o_con_stall,
  output logic              o_con_mem_req,
  output logic              o_con_mem_we,
  output logic [ARB_DW-1:0] o_addr_mem,
  output logic [ARB_DW-1:0] o_data_memw,
  input  logic              i_con_mem_ack,
  input  logic [ARB_DW-1:0] i_data_memr,
  output logic              o_con_err
);

  localparam logic [ARB_WD_W-1:0] TimeoutLimit = ARB_WD_W'(TIMEOUT);

  arb_state_t        r_state;
  logic              r_req;
  logic              r_we;
  logic [ARB_DW-1:0] r_addr;
  logic [ARB_DW-1:0] r_wdata;
  logic [ARB_DW-1:0] r_instr;
  logic [ARB_DW-1:0] r_rdata;
  logic              r_err;
  logic              r_d_done;
  logic              r_i_done;

  logic w_d_pend;
  logic w_i_pend;
  logic w_stall;
  logic w_busy;
  logic w_wd_en;
  logic w_wd_clr;
  logic w_wd_expired;

  assign w_d_pend = (i_con_dread | i_con_dwrite) & ~r_d_done;
  assign w_i_pend = i_con_ireq & ~r_i_done;
  assign w_stall  = w_d_pend | w_i_pend;
  assign w_busy   = (r_state != IDLE);

  // Count every busy cycle without ack; restart whenever an access ends so
  // the next access (possibly chained without IDLE) starts from zero.
  assign w_wd_en  = w_busy & ~i_con_mem_ack;
  assign w_wd_clr = ~w_wd_en | w_wd_expired;

  arb_watchdog u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .i_limit   (TimeoutLimit),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_instr  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_d_done <= 1'b0;
      r_i_done <= 1'b0;
    end else begin
      // The core advances on every edge without stall; its next instruction
      // brings fresh requests.
      if (!w_stall) begin
        r_d_done <= 1'b0;
        r_i_done <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_d_pend) begin
            r_state <= D_BUSY;
            r_req   <= 1'b1;
            r_we    <= i_con_dwrite;
            r_addr  <= i_addr_data;
            r_wdata <= i_data_wdata;
          end else if (w_i_pend) begin
            r_state <= I_BUSY;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= i_addr_instr;
            r_wdata <= '0;
          end
        end

        D_BUSY: begin
          if (i_con_mem_ack) begin
            r_d_done <= 1'b1;
            if (!r_we) begin
              r_rdata <= i_data_memr;
            end
            if (w_i_pend) begin
              // Chain straight into the fetch; req stays high.
              r_state <= I_BUSY;
              r_we    <= 1'b0;
              r_addr  <= i_addr_instr;
              r_wdata <= '0;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
              r_we    <= 1'b0;
            end
          end else if (w_wd_expired) begin
            r_err    <= 1'b1;
            r_d_done <= 1'b1;
            r_rdata  <= '0;
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
          end
        end

        I_BUSY: begin
          if (i_con_mem_ack) begin
            r_i_done <= 1'b1;
            r_instr  <= i_data_memr;
            if (w_d_pend) begin
              r_state <= D_BUSY;
              r_we    <= i_con_dwrite;
              r_addr  <= i_addr_data;
              r_wdata <= i_data_wdata;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
              r_we    <= 1'b0;
            end
          end else if (w_wd_expired) begin
            r_err    <= 1'b1;
            r_i_done <= 1'b1;
            r_instr  <= '0;
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign o_con_stall   = w_stall;
  assign o_con_mem_req = r_req;
  assign o_con_mem_we  = r_we;
  assign o_addr_mem    = r_addr;
  assign o_data_memw   = r_wdata;
  assign o_data_instr  = r_instr;
  assign o_data_rdata  = r_rdata;
  assign o_con_err     = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (watchdog limit 4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_instr;
  logic        dread = 1'b0;
  logic        dwrite = 1'b0;
  logic [31:0] addr_d = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] addr_mem;
  logic [31:0] memw;
  logic        ack;
  logic [31:0] memr;
  logic        err;

  // Memory responder controls
  logic ack_on    = 1'b1;
  logic force_ack = 1'b0;
  int   lat       = 1;
  int   wcnt      = 0;

  int n_chk  = 0;
  int n_pass = 0;

  logic        log_req  [0:63];
  logic        log_we   [0:63];
  logic [31:0] log_addr [0:63];
  logic [31:0] log_wd   [0:63];

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_con_ireq    (ireq),
    .i_addr_instr  (addr_i),
    .o_data_instr  (data_instr),
    .i_con_dread   (dread),
    .i_con_dwrite  (dwrite),
    .i_addr_data   (addr_d),
    .i_data_wdata  (wdata),
    .o_data_rdata  (data_rdata),
    .o_con_stall   (stall),
    .o_con_mem_req (mem_req),
    .o_con_mem_we  (mem_we),
    .o_addr_mem    (addr_mem),
    .o_data_memw   (memw),
    .i_con_mem_ack (ack),
    .i_data_memr   (memr),
    .o_con_err     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 32'h2402_0005;
      32'h104: mem_rd = 32'h8C43_0000;
      32'h108: mem_rd = 32'h2063_0001;
      32'h10C: mem_rd = 32'h1460_FFFE;
      32'h110: mem_rd = 32'hAC43_0004;
      32'h200: mem_rd = 32'h1234_5678;
      default: mem_rd = 32'h5A5A_5A5A;
    endcase
  endfunction

  // Memory model: acks the lat-th cycle of each request.
  initial begin
    ack  = 1'b0;
    memr = '0;
    forever begin
      @(posedge clk);
      #1;
      ack = 1'b0;
      if (force_ack) begin
        ack  = 1'b1;
        memr = 32'hDEAD_BEEF;
      end else if (ack_on && mem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          ack  = 1'b1;
          memr = mem_rd(addr_mem);
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called 2 time units into the request cycle; returns the number of stalled
  // cycles and leaves the bench in the first cycle with stall low.
  task automatic run_access(output int cycles);
    cycles = 0;
    while (stall === 1'b1 && cycles < 40) begin
      log_req[cycles]  = mem_req;
      log_we[cycles]   = mem_we;
      log_addr[cycles] = addr_mem;
      log_wd[cycles]   = memw;
      cycles++;
      @(posedge clk);
      #2;
    end
  endtask

  logic [31:0] bb_a [0:2];
  logic [31:0] bb_d [0:2];

  initial begin
    int n;
    bb_a[0] = 32'h108; bb_a[1] = 32'h10C; bb_a[2] = 32'h110;
    bb_d[0] = 32'h2063_0001; bb_d[1] = 32'h1460_FFFE; bb_d[2] = 32'hAC43_0004;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", addr_mem, 0);
    check("rst_memw", memw, 0);
    check("rst_instr", data_instr, 0);
    check("rst_rdata", data_rdata, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);

    // Fetch only, latency 3
    @(posedge clk); #1;
    lat = 3; ireq = 1'b1; addr_i = 32'h100;
    #1;
    run_access(n);
    check("f_stall_cycles", n, 4);
    check("f_req_n0", log_req[0], 0);
    check("f_req_n1", log_req[1], 1);
    check("f_addr_n1", log_addr[1], 32'h100);
    check("f_we_n1", log_we[1], 0);
    check("f_req_n3", log_req[3], 1);
    check("f_instr", data_instr, 32'h2402_0005);
    check("f_req_after", mem_req, 0);
    @(posedge clk); #1 ireq = 1'b0;
    #1 check("f_stall_idle", stall, 0);

    // Load + fetch together, latency 2 each
    @(posedge clk); #1;
    lat = 2; dread = 1'b1; addr_d = 32'h200; ireq = 1'b1; addr_i = 32'h104;
    #1;
    run_access(n);
    check("lf_stall_cycles", n, 5);
    check("lf_addr_n1", log_addr[1], 32'h200);
    check("lf_addr_n2", log_addr[2], 32'h200);
    check("lf_req_n3", log_req[3], 1);
    check("lf_addr_n3", log_addr[3], 32'h104);
    check("lf_addr_n4", log_addr[4], 32'h104);
    check("lf_rdata", data_rdata, 32'h1234_5678);
    check("lf_instr", data_instr, 32'h8C43_0000);
    check("lf_req_after", mem_req, 0);
    @(posedge clk); #1 dread = 1'b0; ireq = 1'b0;

    // Store, latency 3
    @(posedge clk); #1;
    lat = 3; dwrite = 1'b1; addr_d = 32'h300; wdata = 32'hCAFE_BABE;
    #1;
    run_access(n);
    check("st_stall_cycles", n, 4);
    check("st_we_n1", log_we[1], 1);
    check("st_we_n3", log_we[3], 1);
    check("st_addr_n1", log_addr[1], 32'h300);
    check("st_addr_n3", log_addr[3], 32'h300);
    check("st_wd_n1", log_wd[1], 32'hCAFE_BABE);
    check("st_wd_n3", log_wd[3], 32'hCAFE_BABE);
    check("st_rdata_kept", data_rdata, 32'h1234_5678);
    check("st_we_after", mem_we, 0);
    check("st_err", err, 0);
    @(posedge clk); #1 dwrite = 1'b0;

    // Back-to-back fetches, ack on the first req cycle
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ireq = 1'b1; addr_i = bb_a[i];
      #1;
      run_access(n);
      check("bb_stall_cycles", n, 2);
      check("bb_addr", log_addr[1], bb_a[i]);
      check("bb_instr", data_instr, bb_d[i]);
    end
    @(posedge clk); #1 ireq = 1'b0;

    // Watchdog timeout: no ack at all
    @(posedge clk); #1;
    ack_on = 1'b0; dread = 1'b1; addr_d = 32'h204;
    #1;
    run_access(n);
    check("to_stall_cycles", n, 5);
    check("to_req_n4", log_req[4], 1);
    check("to_req_after", mem_req, 0);
    check("to_err", err, 1);
    check("to_rdata", data_rdata, 0);
    @(posedge clk); #1 dread = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("to_err_sticky", err, 1);

    // Reset in D_BUSY, then a stray ack in IDLE
    @(posedge clk); #1;
    ack_on = 1'b1; lat = 10; dread = 1'b1; addr_d = 32'h208;
    @(posedge clk); #2;
    check("rb_req_busy", mem_req, 1);
    check("rb_addr_busy", addr_mem, 32'h208);
    @(posedge clk); #1 rst = 1'b1; dread = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("rb_req", mem_req, 0);
    check("rb_addr", addr_mem, 0);
    check("rb_instr", data_instr, 0);
    check("rb_rdata", data_rdata, 0);
    check("rb_err", err, 0);
    ack_on = 1'b0; force_ack = 1'b1;
    @(posedge clk); #2 force_ack = 1'b0;
    @(posedge clk); #2;
    check("rb_late_rdata", data_rdata, 0);
    check("rb_late_instr", data_instr, 0);
    check("rb_late_req", mem_req, 0);
    check("rb_late_stall", stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
